// File: rtl/alu_cmd_sequencer.sv
// Shared ALU types plus a sequencer that runs one ALU command over a stream of
// operand pairs, with credit-limited issue and in-order result forwarding.
package alu_pkg;
   localparam int INT_WIDTH      = 8;
   localparam int NUM_WORD_WIDTH = 10;

   typedef enum logic [2:0] {
      ALU_ADD       = 3'd0,
      ALU_SUB       = 3'd1,
      ALU_MUL       = 3'd2,
      ALU_DIV       = 3'd3,
      ALU_MUL_ACCUM = 3'd4
   } ALU_OP_E;

   typedef struct packed {
      logic                 vld;
      logic [INT_WIDTH-1:0] data;
   } uint_vld_t;

   typedef struct packed {
      logic                      vld;
      logic [2:0]                opcode;
      logic [NUM_WORD_WIDTH-1:0] num_words;
   } alu_cmd_t;
endpackage

module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int INT_WIDTH       = alu_pkg::INT_WIDTH,
   parameter int NUM_WORD_WIDTH  = alu_pkg::NUM_WORD_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   input  alu_cmd_t   cmd_i,
   output logic       cmd_rdy_o,
   input  uint_vld_t  opa_i,
   input  uint_vld_t  opb_i,
   output logic       opnd_rdy_o,
   output logic       alu_req_vld_o,
   output logic [2:0] alu_opcode_o,
   output logic [7:0] alu_a_o,
   output logic [7:0] alu_b_o,
   output logic       alu_acc_clr_o,
   input  uint_vld_t  alu_res_i,
   output uint_vld_t  res_o,
   output logic       res_last_o,
   output logic       done_o,
   output logic       busy_o,
   output logic       err_o
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   localparam logic [3:0]                MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [NUM_WORD_WIDTH-1:0] ONE     = NUM_WORD_WIDTH'(1);

   state_e                    state_q, state_d;
   logic [2:0]                opcode_q, opcode_d;
   logic [NUM_WORD_WIDTH-1:0] num_words_q, num_words_d;
   logic [NUM_WORD_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [NUM_WORD_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
   logic [3:0]                outstanding_q, outstanding_d;
   logic                      err_q, err_d;
   logic                      req_vld_q, req_vld_d;
   logic [2:0]                alu_op_q, alu_op_d;
   logic [INT_WIDTH-1:0]      a_q, a_d, b_q, b_d;
   logic                      acc_clr_q, acc_clr_d;
   logic                      res_vld_q, res_vld_d;
   logic [INT_WIDTH-1:0]      res_data_q, res_data_d;
   logic                      res_last_q, res_last_d;

   logic pair_acc;
   logic res_take;
   logic ret_last;

   assign pair_acc = opnd_rdy_o && opa_i.vld && opb_i.vld;
   assign res_take = alu_res_i.vld && (outstanding_q != 4'd0);
   assign ret_last = (ret_cnt_q == num_words_q - ONE);

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      num_words_d   = num_words_q;
      issue_cnt_d   = issue_cnt_q;
      ret_cnt_d     = ret_cnt_q;
      outstanding_d = outstanding_q;
      err_d         = err_q;
      req_vld_d     = 1'b0;
      alu_op_d      = alu_op_q;
      a_d           = a_q;
      b_d           = b_q;
      acc_clr_d     = 1'b0;
      res_vld_d     = 1'b0;
      res_data_d    = res_data_q;
      res_last_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_i.vld) begin
               opcode_d      = cmd_i.opcode;
               num_words_d   = cmd_i.num_words;
               issue_cnt_d   = '0;
               ret_cnt_d     = '0;
               outstanding_d = '0;
               if (cmd_i.opcode > 3'd4) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (cmd_i.num_words == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (pair_acc) begin
               req_vld_d   = 1'b1;
               alu_op_d    = opcode_q;
               a_d         = opa_i.data;
               b_d         = opb_i.data;
               acc_clr_d   = (opcode_q == ALU_MUL_ACCUM) && (issue_cnt_q == '0);
               issue_cnt_d = issue_cnt_q + ONE;
               if (issue_cnt_q == num_words_q - ONE) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (res_take && ret_last) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // A result with nothing in flight is spurious: flag it and drop it.
      if (alu_res_i.vld) begin
         if (outstanding_q == 4'd0) begin
            err_d = 1'b1;
         end else begin
            ret_cnt_d = ret_cnt_q + ONE;
            if ((opcode_q != ALU_MUL_ACCUM) || ret_last) begin
               res_vld_d  = 1'b1;
               res_data_d = alu_res_i.data;
               res_last_d = ret_last;
            end
         end
      end

      case ({pair_acc, res_take})
         2'b10:   outstanding_d = outstanding_q + 4'd1;
         2'b01:   outstanding_d = outstanding_q - 4'd1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         opcode_q      <= '0;
         num_words_q   <= '0;
         issue_cnt_q   <= '0;
         ret_cnt_q     <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         req_vld_q     <= 1'b0;
         alu_op_q      <= '0;
         a_q           <= '0;
         b_q           <= '0;
         acc_clr_q     <= 1'b0;
         res_vld_q     <= 1'b0;
         res_data_q    <= '0;
         res_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         num_words_q   <= num_words_d;
         issue_cnt_q   <= issue_cnt_d;
         ret_cnt_q     <= ret_cnt_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         req_vld_q     <= req_vld_d;
         alu_op_q      <= alu_op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         acc_clr_q     <= acc_clr_d;
         res_vld_q     <= res_vld_d;
         res_data_q    <= res_data_d;
         res_last_q    <= res_last_d;
      end
   end

   assign cmd_rdy_o     = (state_q == S_IDLE);
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign opnd_rdy_o    = (state_q == S_ISSUE) && (outstanding_q < MAX_OUT);
   assign alu_req_vld_o = req_vld_q;
   assign alu_opcode_o  = alu_op_q;
   assign alu_a_o       = a_q;
   assign alu_b_o       = b_q;
   assign alu_acc_clr_o = acc_clr_q;
   assign res_o         = {res_vld_q, res_data_q};
   assign res_last_o    = res_last_q;
   assign err_o         = err_q;
endmodule
